// File: rtl/wb_cmd_pkg.sv
// Shared constants and state encoding for the byte-command Wishbone initiator.
package wb_cmd_pkg;

  // Command opcodes (first byte of a command).
  localparam logic [7:0] OP_WR = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD = 8'h52;  // 'R'

  // Single-byte response codes.
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K' write acknowledged
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E' bus timeout
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown opcode

  typedef enum logic [2:0] {
    StIdle,
    StWAdr,
    StWSel,
    StWDat,
    StRAdr,
    StBus,
    StRsp
  } state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a byte command stream.
// Parses write/read commands, runs one bus cycle each and serialises the reply.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned ADR_W   = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [7:0]       rx_dat,
  input  logic             rx_vld,
  output logic             rx_rdy,
  output logic [7:0]       tx_dat,
  output logic             tx_vld,
  input  logic             tx_rdy,
  output logic             wbm_cyc,
  output logic             wbm_stb,
  output logic             wbm_we,
  output logic [3:0]       wbm_sel,
  output logic [ADR_W-1:0] wbm_adr,
  output logic [31:0]      wbm_dat,
  input  logic [31:0]      wbm_rdt,
  input  logic             wbm_ack,
  output logic             busy
);

  // Last timeout-counter value before the abort fires.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [31:0]      dat_q, dat_d;
  logic [1:0]       idx_q, idx_d;
  logic             cyc_q, cyc_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]      rdt_q, rdt_d;
  logic [7:0]       tx_dat_q, tx_dat_d;
  logic             tx_vld_q, tx_vld_d;
  logic [1:0]       tx_idx_q, tx_idx_d;
  logic [1:0]       tx_cnt_q, tx_cnt_d;

  logic rx_fire;
  logic tx_fire;

  // Command bytes are only taken while a command is still being assembled.
  always_comb begin
    rx_rdy = (state_q == StIdle) || (state_q == StWAdr) || (state_q == StWSel) ||
             (state_q == StWDat) || (state_q == StRAdr);
  end

  assign rx_fire = rx_vld && rx_rdy;
  assign tx_fire = tx_vld_q && tx_rdy;

  // State and datapath registers; async reset clears everything including the bus cycle.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      idx_q    <= '0;
      cyc_q    <= 1'b0;
      to_cnt_q <= '0;
      rdt_q    <= '0;
      tx_dat_q <= '0;
      tx_vld_q <= 1'b0;
      tx_idx_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      to_cnt_q <= to_cnt_d;
      rdt_q    <= rdt_d;
      tx_dat_q <= tx_dat_d;
      tx_vld_q <= tx_vld_d;
      tx_idx_q <= tx_idx_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Next-state: command parsing, bus handshake and response serialisation.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    dat_d    = dat_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    to_cnt_d = to_cnt_q;
    rdt_d    = rdt_q;
    tx_dat_d = tx_dat_q;
    tx_vld_d = tx_vld_q;
    tx_idx_d = tx_idx_q;
    tx_cnt_d = tx_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (rx_dat == OP_WR) begin
            state_d = StWAdr;
          end else if (rx_dat == OP_RD) begin
            state_d = StRAdr;
          end else begin
            tx_dat_d = RSP_BAD;
            tx_vld_d = 1'b1;
            tx_cnt_d = 2'd0;
            state_d  = StRsp;
          end
        end
      end

      StWAdr: begin
        if (rx_fire) begin
          adr_d   = rx_dat[ADR_W-1:0];
          state_d = StWSel;
        end
      end

      StWSel: begin
        if (rx_fire) begin
          sel_d   = rx_dat[3:0];
          idx_d   = 2'd0;
          state_d = StWDat;
        end
      end

      StWDat: begin
        if (rx_fire) begin
          dat_d[8*idx_q +: 8] = rx_dat;
          idx_d               = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d     = 1'b1;
            cyc_d    = 1'b1;
            to_cnt_d = '0;
            state_d  = StBus;
          end
        end
      end

      StRAdr: begin
        if (rx_fire) begin
          adr_d    = rx_dat[ADR_W-1:0];
          sel_d    = 4'hF;
          we_d     = 1'b0;
          cyc_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = StBus;
        end
      end

      StBus: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbm_ack) begin
          rdt_d    = wbm_rdt;
          cyc_d    = 1'b0;
          tx_vld_d = 1'b1;
          tx_idx_d = 2'd0;
          state_d  = StRsp;
          if (we_q) begin
            tx_dat_d = RSP_OK;
            tx_cnt_d = 2'd0;
          end else begin
            tx_dat_d = wbm_rdt[7:0];
            tx_cnt_d = 2'd3;
          end
        end else if (to_cnt_q == ToLast) begin
          cyc_d    = 1'b0;
          tx_dat_d = RSP_ERR;
          tx_vld_d = 1'b1;
          tx_cnt_d = 2'd0;
          state_d  = StRsp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StRsp: begin
        // tx_cnt_q counts bytes still to follow the one currently presented.
        if (tx_fire) begin
          if (tx_cnt_q == 2'd0) begin
            tx_vld_d = 1'b0;
            state_d  = StIdle;
          end else begin
            tx_idx_d = tx_idx_q + 2'd1;
            tx_cnt_d = tx_cnt_q - 2'd1;
            tx_dat_d = rdt_q[8*tx_idx_d +: 8];
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign tx_dat  = tx_dat_q;
  assign tx_vld  = tx_vld_q;
  assign wbm_cyc = cyc_q;
  assign wbm_stb = cyc_q;
  assign wbm_we  = we_q;
  assign wbm_sel = sel_q;
  assign wbm_adr = adr_q;
  assign wbm_dat = dat_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: command-level reference model plus directed scenarios.
module tb_wb_cmd_master;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TO_W    = 5;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [7:0]  rx_dat;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  tx_dat;
  logic        tx_vld;
  logic        tx_rdy;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [7:0]  wbm_adr;
  logic [31:0] wbm_dat;
  logic [31:0] wbm_rdt;
  logic        wbm_ack;
  logic        busy;

  wb_cmd_master #(
    .ADR_W  (8),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .rx_dat  (rx_dat),
    .rx_vld  (rx_vld),
    .rx_rdy  (rx_rdy),
    .tx_dat  (tx_dat),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy),
    .wbm_cyc (wbm_cyc),
    .wbm_stb (wbm_stb),
    .wbm_we  (wbm_we),
    .wbm_sel (wbm_sel),
    .wbm_adr (wbm_adr),
    .wbm_dat (wbm_dat),
    .wbm_rdt (wbm_rdt),
    .wbm_ack (wbm_ack),
    .busy    (busy)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Registered slave: ack one cycle after stb, for one cycle; or never when disabled.
  logic        slave_ack_en = 1'b1;
  logic [31:0] slave_rdt    = 32'h0;
  assign wbm_rdt = slave_rdt;

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) wbm_ack <= 1'b0;
    else           wbm_ack <= slave_ack_en && wbm_cyc && wbm_stb && !wbm_ack;
  end

  // Reference model state (command level).
  logic [7:0]  m_cmd[$];
  logic [7:0]  m_exp_tx[$];
  logic [7:0]  tx_log[$];
  bit          m_pending, m_bus_exp, m_stb_due, m_tx_started, prev_hold;
  logic [7:0]  m_adr;
  logic [3:0]  m_sel;
  logic        m_we;
  logic [31:0] m_dat;
  int          m_len, m_lat, m_acc_cyc;
  int          cyc_n = 0;
  int          stb_len = 0, last_stb_len = 0, bus_cnt = 0;
  logic [7:0]  prev_dat;
  logic [31:0] last_dat;
  logic [3:0]  last_sel;
  logic        last_we;
  logic [7:0]  last_adr;

  // Called on each accepted command byte; on completion derives the expected bus cycle and reply.
  task automatic model_accept(input logic [7:0] b);
    logic       done;
    logic [7:0] op;
    logic [7:0] sb;
    m_cmd.push_back(b);
    op = m_cmd[0];
    if (op == 8'h57)      done = (m_cmd.size() == 7);
    else if (op == 8'h52) done = (m_cmd.size() == 2);
    else                  done = 1'b1;
    if (done) begin
      m_pending    = 1'b1;
      m_acc_cyc    = cyc_n;
      m_tx_started = 1'b0;
      m_exp_tx.delete();
      if (op != 8'h57 && op != 8'h52) begin
        m_exp_tx.push_back(8'h3F);
        m_lat     = 1;
        m_bus_exp = 1'b0;
      end else begin
        m_bus_exp = 1'b1;
        m_stb_due = 1'b1;
        m_adr     = m_cmd[1];
        m_we      = (op == 8'h57);
        if (m_we) begin
          sb    = m_cmd[2];
          m_sel = sb[3:0];
          m_dat = {m_cmd[6], m_cmd[5], m_cmd[4], m_cmd[3]};
        end else begin
          m_sel = 4'hF;
        end
        if (slave_ack_en) begin
          m_len = 2;
          m_lat = 3;
          if (m_we) m_exp_tx.push_back(8'h4B);
          else for (int i = 0; i < 4; i++) m_exp_tx.push_back(slave_rdt[8*i +: 8]);
        end else begin
          m_len = TIMEOUT;
          m_lat = TIMEOUT + 1;
          m_exp_tx.push_back(8'h45);
        end
      end
      m_cmd.delete();
    end
  endtask

  // Compare process: sample mid-cycle, check every output against the model.
  always @(negedge wb_clk) begin
    cyc_n++;
    if (!wb_rst_n) begin
      m_cmd.delete();
      m_exp_tx.delete();
      m_pending = 1'b0;
      m_bus_exp = 1'b0;
      m_stb_due = 1'b0;
      stb_len   = 0;
      prev_hold = 1'b0;
    end else begin
      check("rx_rdy", {31'b0, rx_rdy}, {31'b0, !m_pending});
      check("busy", {31'b0, busy}, {31'b0, (m_cmd.size() > 0) || m_pending});
      if (m_stb_due) begin
        check("stb_start", {31'b0, wbm_stb}, 32'd1);
        m_stb_due = 1'b0;
      end
      if (wbm_cyc || wbm_stb) begin
        check("cyc_eq_stb", {31'b0, wbm_cyc}, {31'b0, wbm_stb});
        check("bus_expected", {31'b0, m_bus_exp}, 32'd1);
        if (stb_len == 0) bus_cnt++;
        stb_len++;
        check("bus_adr", {24'b0, wbm_adr}, {24'b0, m_adr});
        check("bus_sel", {28'b0, wbm_sel}, {28'b0, m_sel});
        check("bus_we", {31'b0, wbm_we}, {31'b0, m_we});
        if (m_we) check("bus_dat", wbm_dat, m_dat);
        last_dat = wbm_dat;
        last_sel = wbm_sel;
        last_we  = wbm_we;
        last_adr = wbm_adr;
      end else if (stb_len > 0) begin
        check("stb_len", stb_len, m_len);
        last_stb_len = stb_len;
        stb_len      = 0;
        m_bus_exp    = 1'b0;
      end
      if (tx_vld) begin
        if (!m_tx_started) begin
          check("tx_latency", cyc_n - m_acc_cyc, m_lat);
          m_tx_started = 1'b1;
        end
        if (prev_hold) check("tx_hold", {24'b0, tx_dat}, {24'b0, prev_dat});
        if (tx_rdy) begin
          if (m_exp_tx.size() == 0) begin
            fail_now("tx_unexpected_byte");
          end else begin
            check("tx_byte", {24'b0, tx_dat}, {24'b0, m_exp_tx.pop_front()});
            if (m_exp_tx.size() == 0) m_pending = 1'b0;
          end
          tx_log.push_back(tx_dat);
        end
      end else if (prev_hold) begin
        check("tx_vld_held", {31'b0, tx_vld}, 32'd1);
      end
      prev_hold = tx_vld && !tx_rdy;
      prev_dat  = tx_dat;
      if (rx_vld && rx_rdy) model_accept(rx_dat);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok     = 1'b0;
    rx_dat = b;
    rx_vld = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge wb_clk);
      if (rx_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("rx_accept");
    @(posedge wb_clk);
    #1;
    rx_vld = 1'b0;
  endtask

  task automatic write_cmd(input logic [7:0] adr, input logic [7:0] sel, input logic [31:0] d);
    send_byte(8'h57);
    send_byte(adr);
    send_byte(sel);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic read_cmd(input logic [7:0] adr);
    send_byte(8'h52);
    send_byte(adr);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge wb_clk);
      if (!busy && !m_pending) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_done");
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bit ok;
    wb_rst_n = 1'b0;
    rx_vld   = 1'b0;
    rx_dat   = 8'h00;
    tx_rdy   = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_rx_rdy", {31'b0, rx_rdy}, 32'd1);
    check("rst_tx_vld", {31'b0, tx_vld}, 32'd0);
    check("rst_cyc", {31'b0, wbm_cyc}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dat", wbm_dat, 32'd0);
    wb_rst_n = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;

    // Write, registered-ack slave.
    tx_log.delete();
    write_cmd(8'h00, 8'h01, 32'h0000_00A5);
    wait_done();
    check("wr_dat", last_dat, 32'h0000_00A5);
    check("wr_sel", {28'b0, last_sel}, 32'h1);
    check("wr_we", {31'b0, last_we}, 32'd1);
    check("wr_adr", {24'b0, last_adr}, 32'h0);
    check("wr_stb_len", last_stb_len, 2);
    check("wr_rsp_n", tx_log.size(), 1);
    check("wr_rsp", {24'b0, tx_log[0]}, 32'h4B);
    check("wr_busy", {31'b0, busy}, 32'd0);

    // Read, slave returns 8000_1234.
    tx_log.delete();
    slave_rdt = 32'h8000_1234;
    read_cmd(8'h0C);
    wait_done();
    check("rd_sel", {28'b0, last_sel}, 32'hF);
    check("rd_we", {31'b0, last_we}, 32'd0);
    check("rd_adr", {24'b0, last_adr}, 32'h0C);
    check("rd_n", tx_log.size(), 4);
    check("rd_b0", {24'b0, tx_log[0]}, 32'h34);
    check("rd_b1", {24'b0, tx_log[1]}, 32'h12);
    check("rd_b2", {24'b0, tx_log[2]}, 32'h00);
    check("rd_b3", {24'b0, tx_log[3]}, 32'h80);
    check("rd_rx_rdy", {31'b0, rx_rdy}, 32'd1);

    // Read timeout, then a normal write.
    tx_log.delete();
    slave_ack_en = 1'b0;
    read_cmd(8'h10);
    wait_done();
    check("to_stb_len", last_stb_len, 16);
    check("to_n", tx_log.size(), 1);
    check("to_rsp", {24'b0, tx_log[0]}, 32'h45);
    slave_ack_en = 1'b1;
    tx_log.delete();
    write_cmd(8'h20, 8'hF3, 32'h4433_2211);
    wait_done();
    check("post_to_dat", last_dat, 32'h4433_2211);
    check("post_to_sel", {28'b0, last_sel}, 32'h3);
    check("post_to_rsp", {24'b0, tx_log[0]}, 32'h4B);

    // Unknown opcode: no bus activity.
    tx_log.delete();
    bc = bus_cnt;
    send_byte(8'h00);
    wait_done();
    check("bad_no_bus", bus_cnt, bc);
    check("bad_n", tx_log.size(), 1);
    check("bad_rsp", {24'b0, tx_log[0]}, 32'h3F);

    // Read with a slow sink: 10 stalled cycles before each byte.
    tx_log.delete();
    tx_rdy    = 1'b0;
    slave_rdt = 32'hDEAD_BEEF;
    read_cmd(8'h33);
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge wb_clk);
        if (tx_vld) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("slow_tx_vld");
      repeat (10) @(posedge wb_clk);
      #1;
      tx_rdy = 1'b1;
      @(posedge wb_clk);
      #1;
      tx_rdy = 1'b0;
    end
    tx_rdy = 1'b1;
    wait_done();
    check("slow_n", tx_log.size(), 4);
    check("slow_b0", {24'b0, tx_log[0]}, 32'hEF);
    check("slow_b1", {24'b0, tx_log[1]}, 32'hBE);
    check("slow_b2", {24'b0, tx_log[2]}, 32'hAD);
    check("slow_b3", {24'b0, tx_log[3]}, 32'hDE);

    // Reset while stb is high, then a fresh write.
    slave_ack_en = 1'b0;
    read_cmd(8'h44);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge wb_clk);
      if (wbm_stb) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("rst_wait_stb");
    @(posedge wb_clk);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", {31'b0, wbm_cyc}, 32'd0);
    check("mid_rst_stb", {31'b0, wbm_stb}, 32'd0);
    check("mid_rst_tx_vld", {31'b0, tx_vld}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst_n     = 1'b1;
    slave_ack_en = 1'b1;
    tx_log.delete();
    @(posedge wb_clk);
    #1;
    write_cmd(8'h04, 8'h0F, 32'h0403_0201);
    wait_done();
    check("after_rst_dat", last_dat, 32'h0403_0201);
    check("after_rst_adr", {24'b0, last_adr}, 32'h04);
    check("after_rst_n", tx_log.size(), 1);
    check("after_rst_rsp", {24'b0, tx_log[0]}, 32'h4B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
